// File: rtl/hamming_distance.sv
// hamming_distance: three-stage pipelined XOR + grouped popcount of two census codes
module hamming_distance #(
  parameter int CENSUS_WIDTH = 8,
  parameter int GROUP_WIDTH = 4,
  localparam int DIST_WIDTH = $clog2(CENSUS_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CENSUS_WIDTH-1:0] census_left,
  input  logic [CENSUS_WIDTH-1:0] census_right,
  input  logic                    valid_in,
  output logic [DIST_WIDTH-1:0]   hamming_dist,
  output logic                    valid_out
);
  localparam int NG = (CENSUS_WIDTH + GROUP_WIDTH - 1) / GROUP_WIDTH;
  localparam int PW = $clog2(GROUP_WIDTH + 1);
  logic [CENSUS_WIDTH-1:0]    x;
  logic [NG*GROUP_WIDTH-1:0]  xp;
  logic [PW-1:0]              pc [NG];
  logic [PW-1:0]              part [NG];
  logic [DIST_WIDTH-1:0]      sum;
  logic                       v1, v2;
  // top group is zero-padded so every group has GROUP_WIDTH bits
  assign xp = (NG*GROUP_WIDTH)'(x);
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      pc[g] = '0;
      for (int b = 0; b < GROUP_WIDTH; b++) pc[g] = pc[g] + PW'(xp[g*GROUP_WIDTH+b]);
    end
  end
  always_comb begin
    sum = '0;
    for (int g = 0; g < NG; g++) sum = sum + DIST_WIDTH'(part[g]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x            <= '0;
      v1           <= 1'b0;
      part         <= '{default: '0};
      v2           <= 1'b0;
      hamming_dist <= '0;
      valid_out    <= 1'b0;
    end else begin
      v1        <= valid_in;
      v2        <= v1;
      valid_out <= v2;
      if (valid_in) x <= census_left ^ census_right;
      if (v1) part <= pc;
      if (v2) hamming_dist <= sum;
    end
  end
endmodule

// File: tb/tb_hamming_distance.sv
// tb_hamming_distance: directed and streaming checks against a due-cycle scoreboard model
module tb_hamming_distance;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] left = '0, right = '0;
  logic       vin = 1'b0;
  logic [3:0] hamming_dist;
  logic       valid_out;
  int         passed = 0, total = 0;

  typedef struct { int due; int val; } ent_t;
  ent_t       pend [$];
  int         cyc = 0;
  int         exp_d = 0;
  logic       exp_v = 1'b0;
  logic       started = 1'b0;

  hamming_distance dut (
    .clk(clk), .rst(rst), .census_left(left), .census_right(right),
    .valid_in(vin), .hamming_dist(hamming_dist), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  // result of a pair accepted at edge k is due at edge k+2; reset drops everything pending
  always @(posedge clk) begin
    ent_t e;
    cyc++;
    if (rst) begin
      pend.delete();
      exp_d = 0;
      exp_v = 1'b0;
      started = 1'b1;
    end else begin
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_d = pend[0].val;
        exp_v = 1'b1;
        void'(pend.pop_front());
      end
      if (vin) begin
        e.due = cyc + 2;
        e.val = $countones(left ^ right);
        pend.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_valid_out", valid_out, exp_v);
      chk("model_dist", hamming_dist, exp_d);
    end
  end

  task automatic pulse(input logic [7:0] l, input logic [7:0] r, input int e, input string nm);
    @(negedge clk); left = l; right = r; vin = 1'b1;
    @(negedge clk); vin = 1'b0; left = 8'($urandom); right = 8'($urandom);
    @(negedge clk);
    chk({nm, "_early"}, valid_out, 0);
    @(negedge clk);
    chk({nm, "_valid"}, valid_out, 1);
    chk({nm, "_dist"}, hamming_dist, e);
    @(negedge clk);
    chk({nm, "_drop"}, valid_out, 0);
    chk({nm, "_hold"}, hamming_dist, e);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valid", valid_out, 0);
    chk("reset_dist", hamming_dist, 0);
    rst = 1'b0;
    pulse(8'b01010101, 8'b01010101, 0, "identical");
    pulse(8'b11111111, 8'b00000000, 8, "full");
    pulse(8'b10101010, 8'b10101011, 1, "single_a");
    pulse(8'b01110010, 8'b01010010, 1, "single_b");
    pulse(8'b11110000, 8'b00001111, 8, "halves");
    pulse(8'b11000011, 8'b10000010, 2, "two_groups");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); left = 8'($urandom); right = 8'($urandom); vin = 1'b1;
    end
    @(negedge clk); vin = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); left = 8'($urandom); right = 8'($urandom); vin = 1'b1;
      @(negedge clk); vin = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    pulse(8'b00000111, 8'b00000000, 3, "pre_reset");
    @(negedge clk); left = 8'hFF; right = 8'h00; vin = 1'b1;
    @(negedge clk); vin = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_dist", hamming_dist, 0);
    chk("rst_valid", valid_out, 0);
    @(negedge clk);
    chk("rst_no_pulse", valid_out, 0);
    pulse(8'b00111100, 8'b00000000, 4, "post_reset");
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hamming_distance.md
Name: hamming_distance

Overview:
Pipelined Hamming-distance unit for the stereo census-matching datapath. It XORs a left and a right census code and counts the differing bits with a registered popcount tree. It sits between the census-transform stage and the cost-aggregation / disparity-selection stage, and accepts one code pair per clock.

Parameters:
- CENSUS_WIDTH, default 8: bit width of each census code; legal range is 1 or more.
- GROUP_WIDTH, default 4: bits per first-level partial popcount group; legal range is 1 or more.
- DIST_WIDTH, default $clog2(CENSUS_WIDTH+1), which is 4 for the default width: width of the distance output. This is a derived localparam, not overridden.

Ports:
- clk, input, 1: sole clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- census_left, input, CENSUS_WIDTH: left-image census code.
- census_right, input, CENSUS_WIDTH: right-image census code.
- valid_in, input, 1: input pair is valid this cycle.
- hamming_dist, output, DIST_WIDTH: number of bit positions where the two codes differ.
- valid_out, output, 1: hamming_dist carries a new result this cycle.

Behaviour:
- Reset:
  - While rst is high at a rising edge, all pipeline data registers, all valid flags, hamming_dist and valid_out clear to 0.
  - Reset wins over valid_in in the same cycle.
  - Reset mid-flight discards every in-flight result; no valid_out pulse follows for those inputs.
- Stage 1, at edge k with valid_in=1:
  - Register x = census_left ^ census_right.
  - Register v1 = 1.
  - When valid_in=0: v1 = 0 and the x register holds its value.
- Stage 2, at edge k+1 when v1=1:
  - Split x into ceil(CENSUS_WIDTH/GROUP_WIDTH) groups of GROUP_WIDTH bits, LSB-first.
  - The top group is zero-padded.
  - Register each group's popcount, each $clog2(GROUP_WIDTH+1) bits wide.
  - Register v2 = 1.
  - When v1=0: v2 = 0 and the partial-sum registers hold.
- Stage 3, at edge k+2 when v2=1:
  - hamming_dist is the sum of all partial popcounts, zero-extended to DIST_WIDTH.
  - valid_out = 1.
  - When v2=0: valid_out = 0 and hamming_dist holds.
- Latency: the result for inputs sampled at edge k is visible immediately after edge k+2. valid_out is high for exactly one cycle per accepted input.
- hamming_dist holds the last valid result indefinitely until the next valid result or reset. Consumers may sample it after valid_out has dropped.
- Throughput: one result per clock. Back-to-back valid_in produces back-to-back valid_out in input order, with no bubbles and no stalls. There is no backpressure.
- Range and arithmetic:
  - The result is always in 0..CENSUS_WIDTH and never overflows DIST_WIDTH.
  - An all-ones XOR gives exactly CENSUS_WIDTH.
  - Arithmetic is unsigned.
- Input values when valid_in=0 are don't-care and must not change any output.
- There is no combinational path from inputs to outputs.

Test Plan:
- Identical codes: left=01010101, right=01010101, one valid pulse -> valid_out is a single pulse 2 edges after the sample edge; hamming_dist=0 and is still 0 one cycle after valid_out falls.
- Full mismatch: left=11111111, right=00000000 -> hamming_dist=8, which is the maximum with no overflow.
- Single-bit difference cases:
  - left=10101010, right=10101011 -> 1.
  - left=01110010, right=01010010 -> 1.
- Complementary halves: left=11110000, right=00001111 -> 8. This checks the cross-group summation.
- Streaming: 10 consecutive valid pairs of random codes with valid_in held high -> 10 consecutive valid_out cycles, each equal to popcount(left^right) of its own pair and in order. Then 10 isolated pulses with 5 idle cycles between them -> each produces exactly one valid_out, and hamming_dist holds between pulses.
- Reset: assert rst one cycle after a valid input -> no valid_out for that input; hamming_dist=0 and valid_out=0 after reset. The next input after reset produces its correct result with 3-stage latency.
